instruction_assembler: RTL and testbench

- Inverse of the opcode decode path: takes a command code and addressing-mode code (the `cmd`/`address` encodings defined in source/param_file.sv) plus a 16-bit operand.
- Emits the equivalent 6502 machine-code byte stream: opcode, then 0–2 operand bytes, little-endian.
- Sits between the debug/test-injection port and the instruction fetch bus; lets benches and the debug controller feed instructions by mnemonic.
- Uses valid/ready handshakes on both sides and flags illegal cmd/mode combinations.

---
 rtl/instruction_assembler_if.sv | 57 +++++
 rtl/instruction_assembler.sv | 231 +++++++++++++++++++++++
 tb/tb_instruction_assembler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/instruction_assembler_if.sv
// Purpose: command/mode encodings and the handshake bundle for the
//          instruction assembler.
// Package instruction_assembler_pkg: 6-bit cmd codes, 4-bit addressing-mode codes.
// Interface instruction_assembler_if:
//   in_valid/in_ready/in_cmd/in_mode/in_operand  request side
//   out_valid/out_ready/out_byte/out_last        byte stream side
//   err                                          illegal cmd/mode pulse
//   modport master: request source / byte consumer; modport slave: assembler.
package instruction_assembler_pkg;
  // ALU group: the low 3 bits are the opcode 'a' field
  localparam logic [5:0] C_ORA  = 6'd0,  C_AND  = 6'd1,  C_EOR  = 6'd2,  C_ADC  = 6'd3;
  localparam logic [5:0] C_STA  = 6'd4,  C_LDA  = 6'd5,  C_CMP  = 6'd6,  C_SBC  = 6'd7;
  // c=10 group: the low 3 bits are the opcode 'a' field
  localparam logic [5:0] C_ASL  = 6'd8,  C_ROL  = 6'd9,  C_LSR  = 6'd10, C_ROR  = 6'd11;
  localparam logic [5:0] C_STX  = 6'd12, C_LDX  = 6'd13, C_DEC  = 6'd14, C_INC  = 6'd15;
  localparam logic [5:0] C_ASLA = 6'd16, C_ROLA = 6'd17, C_LSRA = 6'd18, C_RORA = 6'd19;
  localparam logic [5:0] C_BIT  = 6'd20, C_STY  = 6'd21, C_LDY  = 6'd22, C_CPY  = 6'd23;
  localparam logic [5:0] C_CPX  = 6'd24, C_JMP  = 6'd25;
  // branches in opcode order (10,30,...,F0)
  localparam logic [5:0] C_BPL  = 6'd26, C_BMI  = 6'd27, C_BVC  = 6'd28, C_BVS  = 6'd29;
  localparam logic [5:0] C_BCC  = 6'd30, C_BCS  = 6'd31, C_BNE  = 6'd32, C_BEQ  = 6'd33;
  localparam logic [5:0] C_BRK  = 6'd34, C_JSR  = 6'd35, C_RTI  = 6'd36, C_RTS  = 6'd37;
  localparam logic [5:0] C_PHP  = 6'd38, C_PLP  = 6'd39, C_PHA  = 6'd40, C_PLA  = 6'd41;
  localparam logic [5:0] C_DEY  = 6'd42, C_TAY  = 6'd43, C_INY  = 6'd44, C_INX  = 6'd45;
  localparam logic [5:0] C_CLC  = 6'd46, C_SEC  = 6'd47, C_CLI  = 6'd48, C_SEI  = 6'd49;
  localparam logic [5:0] C_TYA  = 6'd50, C_CLV  = 6'd51, C_CLD  = 6'd52, C_SED  = 6'd53;
  localparam logic [5:0] C_TXA  = 6'd54, C_TXS  = 6'd55, C_TAX  = 6'd56, C_TSX  = 6'd57;
  localparam logic [5:0] C_DEX  = 6'd58, C_NOP  = 6'd59;

  localparam logic [3:0] M_IMPL = 4'd0,  M_A    = 4'd1,  M_IMM  = 4'd2,  M_ZPG  = 4'd3;
  localparam logic [3:0] M_ZPGX = 4'd4,  M_ZPGY = 4'd5,  M_XIND = 4'd6,  M_INDY = 4'd7;
  localparam logic [3:0] M_REL  = 4'd8,  M_ABS  = 4'd9,  M_ABSX = 4'd10, M_ABSY = 4'd11;
  localparam logic [3:0] M_IND  = 4'd12;
endpackage

interface instruction_assembler_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_cmd;
  logic [3:0]  in_mode;
  logic [15:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        err;

  modport master (
    output in_valid, in_cmd, in_mode, in_operand, out_ready,
    input  in_ready, out_valid, out_byte, out_last, err
  );

  modport slave (
    input  in_valid, in_cmd, in_mode, in_operand, out_ready,
    output in_ready, out_valid, out_byte, out_last, err
  );
endinterface

// File: rtl/instruction_assembler.sv
// Purpose: turns a (cmd, addressing mode, operand) request into the 6502
//          machine-code byte stream: opcode, then 0-2 operand bytes, little-endian.
// Ports:
//   clk   system clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   instruction_assembler_if.slave (request in, byte stream out, err)
// Illegal cmd/mode pairs raise err for one cycle and emit nothing.
module instruction_assembler
  import instruction_assembler_pkg::*;
(
  input logic                    clk,
  input logic                    nrst,
  instruction_assembler_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_OP, S_LO, S_HI} state_t;

  // Returns {legal, length[1:0], opcode[7:0]}. Opcode is {a, b, c}.
  function automatic logic [10:0] lookup(input logic [5:0] cmd, input logic [3:0] mode);
    logic       ok;
    logic [7:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] len;
    logic       xy;
    ok = 1'b0;
    op = 8'h00;
    a  = 3'd0;
    b  = 3'd0;
    case (mode)
      M_IMPL, M_A:                 len = 2'd1;
      M_ABS, M_ABSX, M_ABSY, M_IND: len = 2'd3;
      default:                     len = 2'd2;
    endcase
    if (cmd <= C_SBC) begin
      ok = 1'b1;
      case (mode)
        M_XIND:  b = 3'd0;
        M_ZPG:   b = 3'd1;
        M_IMM:   b = 3'd2;
        M_ABS:   b = 3'd3;
        M_INDY:  b = 3'd4;
        M_ZPGX:  b = 3'd5;
        M_ABSY:  b = 3'd6;
        M_ABSX:  b = 3'd7;
        default: ok = 1'b0;
      endcase
      if (cmd == C_STA && mode == M_IMM) ok = 1'b0;
      op = {cmd[2:0], b, 2'b01};
    end else if (cmd <= C_INC) begin
      a  = cmd[2:0];
      // STX/LDX index by Y where the others index by X
      xy = (a == 3'd4) || (a == 3'd5);
      case (mode)
        M_ZPG:   begin b = 3'd1; ok = 1'b1;         end
        M_ABS:   begin b = 3'd3; ok = 1'b1;         end
        M_ZPGX:  begin b = 3'd5; ok = !xy;          end
        M_ABSX:  begin b = 3'd7; ok = !xy;          end
        M_ZPGY:  begin b = 3'd5; ok = xy;           end
        M_ABSY:  begin b = 3'd7; ok = (a == 3'd5);  end
        M_IMM:   begin b = 3'd0; ok = (a == 3'd5);  end
        default: ok = 1'b0;
      endcase
      op = {a, b, 2'b10};
    end else if (cmd <= C_RORA) begin
      ok = (mode == M_IMPL) || (mode == M_A);
      op = {1'b0, cmd[1:0], 5'b01010};
    end else if (cmd <= C_CPX) begin
      case (cmd)
        C_BIT:   a = 3'd1;
        C_STY:   a = 3'd4;
        C_LDY:   a = 3'd5;
        C_CPY:   a = 3'd6;
        default: a = 3'd7;
      endcase
      case (mode)
        M_ZPG:   begin b = 3'd1; ok = 1'b1;                       end
        M_ABS:   begin b = 3'd3; ok = 1'b1;                       end
        M_IMM:   begin b = 3'd0; ok = (a >= 3'd5);                end
        M_ZPGX:  begin b = 3'd5; ok = (a == 3'd4) || (a == 3'd5); end
        M_ABSX:  begin b = 3'd7; ok = (a == 3'd5);                end
        default: ok = 1'b0;
      endcase
      op = {a, b, 2'b00};
    end else if (cmd == C_JMP) begin
      ok = (mode == M_ABS) || (mode == M_IND);
      op = (mode == M_IND) ? 8'h6C : 8'h4C;
    end else if (cmd <= C_BEQ) begin
      ok = (mode == M_REL);
      a  = 3'(cmd - C_BPL);
      op = {a, 5'b10000};
    end else if (cmd == C_JSR) begin
      ok = (mode == M_ABS);
      op = 8'h20;
    end else if (mode == M_IMPL) begin
      ok = 1'b1;
      case (cmd)
        C_BRK: op = 8'h00;  C_RTI: op = 8'h40;  C_RTS: op = 8'h60;
        C_PHP: op = 8'h08;  C_PLP: op = 8'h28;  C_PHA: op = 8'h48;  C_PLA: op = 8'h68;
        C_DEY: op = 8'h88;  C_TAY: op = 8'hA8;  C_INY: op = 8'hC8;  C_INX: op = 8'hE8;
        C_CLC: op = 8'h18;  C_SEC: op = 8'h38;  C_CLI: op = 8'h58;  C_SEI: op = 8'h78;
        C_TYA: op = 8'h98;  C_CLV: op = 8'hB8;  C_CLD: op = 8'hD8;  C_SED: op = 8'hF8;
        C_TXA: op = 8'h8A;  C_TXS: op = 8'h9A;  C_TAX: op = 8'hAA;  C_TSX: op = 8'hBA;
        C_DEX: op = 8'hCA;  C_NOP: op = 8'hEA;
        default: ok = 1'b0;
      endcase
    end
    return {ok, len, op};
  endfunction

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_last_q, out_last_d;
  logic        err_q, err_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [1:0]  len_q, len_d;
  logic        legal_q, legal_d;
  logic [15:0] operand_q, operand_d;
  logic [10:0] lk;
  logic        fire_out;

  // Lookup is done on the request itself and registered at capture, so the
  // result (and err) is already stable during CHECK.
  assign lk       = lookup(bus.in_cmd, bus.in_mode);
  assign fire_out = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    opcode_d    = opcode_q;
    len_d       = len_q;
    legal_d     = legal_q;
    operand_d   = operand_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = S_CHECK;
          in_ready_d = 1'b0;
          opcode_d   = lk[7:0];
          len_d      = lk[9:8];
          legal_d    = lk[10];
          operand_d  = bus.in_operand;
          err_d      = !lk[10];
        end
      end
      S_CHECK: begin
        if (legal_q) begin
          state_d     = S_OP;
          out_valid_d = 1'b1;
          out_byte_d  = opcode_q;
          out_last_d  = (len_q == 2'd1);
        end else begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end
      end
      S_OP: begin
        if (fire_out) begin
          if (len_q == 2'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_LO;
            out_byte_d = operand_q[7:0];
            out_last_d = (len_q == 2'd2);
          end
        end
      end
      S_LO: begin
        if (fire_out) begin
          if (len_q == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_HI;
            out_byte_d = operand_q[15:8];
            out_last_d = 1'b1;
          end
        end
      end
      S_HI: begin
        if (fire_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Leaving the byte states for IDLE closes out the instruction.
    if (state_q != S_IDLE && state_q != S_CHECK && state_d == S_IDLE) begin
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_byte_d  = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      opcode_q    <= 8'h00;
      len_q       <= 2'd0;
      legal_q     <= 1'b0;
      operand_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      opcode_q    <= opcode_d;
      len_q       <= len_d;
      legal_q     <= legal_d;
      operand_q   <= operand_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: hand-computed byte streams,
// stall patterns, illegal pair and mid-instruction reset.
module tb_instruction_assembler;
  import instruction_assembler_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  instruction_assembler_if bus ();

  instruction_assembler dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge and returns at the negedge of the CHECK cycle.
  task automatic send(input logic [5:0] cmd, input logic [3:0] mode, input logic [15:0] opnd);
    int waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("send_in_ready", bus.in_ready, 1'b1);
    bus.in_valid   = 1'b1;
    bus.in_cmd     = cmd;
    bus.in_mode    = mode;
    bus.in_operand = opnd;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Collects n bytes; pat[k] is out_ready for the k-th cycle with out_valid=1.
  task automatic rx(input string tag, input int n, input logic [7:0] e0, input logic [7:0] e1,
                    input logic [7:0] e2, input logic [7:0] pat);
    logic [7:0] exp_b [3];
    int idx = 0;
    int k = 0;
    int cyc = 0;
    int first_cyc = -1;
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    while (idx < n && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        check($sformatf("%s_byte%0d", tag, idx), bus.out_byte, exp_b[idx]);
        check($sformatf("%s_last%0d", tag, idx), bus.out_last, (idx == n - 1));
        bus.out_ready = (k < 8) ? pat[k] : 1'b1;
        k++;
        if (bus.out_ready) idx++;
      end
    end
    check({tag, "_latency"}, first_cyc, 1);
    check({tag, "_count"}, idx, n);
    @(negedge clk);
    check({tag, "_done_valid"}, bus.out_valid, 1'b0);
    check({tag, "_done_ready"}, bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_cmd     = 6'd0;
    bus.in_mode    = 4'd0;
    bus.in_operand = 16'h0000;
    bus.out_ready  = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_out_byte", bus.out_byte, 8'h00);
    end
    nrst = 1'b1;

    send(C_LDA, M_IMM, 16'h0042);
    check("lda_check_valid", bus.out_valid, 1'b0);
    check("lda_check_err", bus.err, 1'b0);
    rx("lda_imm", 2, 8'hA9, 8'h42, 8'h00, 8'hFF);

    send(C_STA, M_ABS, 16'h1234);
    rx("sta_abs_stall", 3, 8'h8D, 8'h34, 8'h12, 8'b1111_1001);

    send(C_NOP, M_IMPL, 16'h0000);
    rx("nop", 1, 8'hEA, 8'h00, 8'h00, 8'hFF);
    send(C_JMP, M_IND, 16'hABCD);
    rx("jmp_ind", 3, 8'h6C, 8'hCD, 8'hAB, 8'hFF);

    send(C_STA, M_IMM, 16'h0055);
    check("sta_imm_err", bus.err, 1'b1);
    check("sta_imm_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    check("sta_imm_err_clear", bus.err, 1'b0);
    check("sta_imm_valid2", bus.out_valid, 1'b0);
    check("sta_imm_ready", bus.in_ready, 1'b1);
    send(C_LDX, M_ZPGY, 16'h0010);
    rx("ldx_zpgy", 2, 8'hB6, 8'h10, 8'h00, 8'hFF);

    send(C_DEC, M_ZPG, 16'h0077);
    rx("dec_zpg", 2, 8'hC6, 8'h77, 8'h00, 8'hFF);
    send(C_ASLA, M_A, 16'h0000);
    rx("asla", 1, 8'h0A, 8'h00, 8'h00, 8'hFF);
    send(C_JSR, M_ABS, 16'h5678);
    rx("jsr", 3, 8'h20, 8'h78, 8'h56, 8'hFF);
    send(C_BNE, M_REL, 16'h00FE);
    rx("bne", 2, 8'hD0, 8'hFE, 8'h00, 8'hFF);
    send(C_TXS, M_IMPL, 16'h0000);
    rx("txs", 1, 8'h9A, 8'h00, 8'h00, 8'hFF);

    send(C_STA, M_ABS, 16'h1234);
    @(negedge clk);
    check("abort_op", bus.out_byte, 8'h8D);
    @(negedge clk);
    check("abort_lo", bus.out_byte, 8'h34);
    #2 nrst = 1'b0;
    #1;
    check("abort_valid", bus.out_valid, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_byte", bus.out_byte, 8'h00);
    check("abort_last", bus.out_last, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    send(C_INC, M_ABSX, 16'h2000);
    rx("inc_absx", 3, 8'hFE, 8'h00, 8'h20, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
